// File: rtl/ht_head_table_stage.sv
// ht_head_table_stage: hashes an incoming command key to a bucket, reads the
// bucket's head pointer from an internal RAM and emits a pdata beat downstream.
// The stage owns the head RAM: it sweeps the RAM clear after reset and then
// takes head updates from the data-table stage through a write port. Head
// writes to a bucket that is in flight are forwarded into the pipeline so a
// transferred beat always reflects the latest head.
module ht_head_table_stage #(
  parameter int    KEY_WIDTH      = 48,
  parameter int    VALUE_WIDTH    = 16,
  parameter int    BUCKET_WIDTH   = 8,
  parameter int    HEAD_PTR_WIDTH = 10,
  parameter string HASH_TYPE      = "dummy"
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [KEY_WIDTH-1:0]      cmd_key_i,
  input  logic [VALUE_WIDTH-1:0]    cmd_value_i,
  input  logic [1:0]                cmd_opcode_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  output logic [KEY_WIDTH-1:0]      pdata_key_o,
  output logic [VALUE_WIDTH-1:0]    pdata_value_o,
  output logic [1:0]                pdata_opcode_o,
  output logic [BUCKET_WIDTH-1:0]   pdata_bucket_o,
  output logic [HEAD_PTR_WIDTH-1:0] pdata_head_ptr_o,
  output logic                      pdata_head_ptr_val_o,
  output logic                      pdata_valid_o,
  input  logic                      pdata_ready_i,
  input  logic                      head_wr_en_i,
  input  logic [BUCKET_WIDTH-1:0]   head_wr_bucket_i,
  input  logic [HEAD_PTR_WIDTH-1:0] head_wr_ptr_i,
  input  logic                      head_wr_ptr_val_i,
  output logic                      init_done_o
);

  localparam int DEPTH      = 1 << BUCKET_WIDTH;
  localparam int NUM_CHUNKS = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
  localparam int KEY_PAD_W  = NUM_CHUNKS * BUCKET_WIDTH;
  localparam int HEAD_W     = HEAD_PTR_WIDTH + 1;   // {val, ptr}

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [BUCKET_WIDTH-1:0] LAST_BUCKET = '1;
  localparam logic [BUCKET_WIDTH-1:0] ONE_BUCKET  = BUCKET_WIDTH'(1);

  logic                    state_reg;
  logic [BUCKET_WIDTH-1:0] init_cnt_reg;
  logic                    run;

  // s1: accepted command waiting for its RAM read data
  logic                    s1_valid_reg;
  logic [KEY_WIDTH-1:0]    s1_key_reg;
  logic [VALUE_WIDTH-1:0]  s1_value_reg;
  logic [1:0]              s1_opcode_reg;
  logic [BUCKET_WIDTH-1:0] s1_bucket_reg;
  logic                    s1_byp_reg;       // a write overtook the RAM read
  logic [HEAD_W-1:0]       s1_byp_data_reg;

  // output register
  logic                    out_valid_reg;
  logic [KEY_WIDTH-1:0]    out_key_reg;
  logic [VALUE_WIDTH-1:0]  out_value_reg;
  logic [1:0]              out_opcode_reg;
  logic [BUCKET_WIDTH-1:0] out_bucket_reg;
  logic [HEAD_W-1:0]       out_head_reg;

  logic [HEAD_W-1:0]       head_mem [DEPTH];
  logic [HEAD_W-1:0]       ram_q;

  logic [BUCKET_WIDTH-1:0] cmd_bucket;
  logic                    accept;
  logic                    s1_adv;
  logic                    out_load;
  logic                    wr_en;
  logic [HEAD_W-1:0]       wr_data;
  logic                    wr_hit_cmd;
  logic                    wr_hit_s1;
  logic                    wr_hit_out;
  logic [HEAD_W-1:0]       s1_head;
  logic [HEAD_W-1:0]       s1_head_fwd;
  logic                    mem_we;
  logic [BUCKET_WIDTH-1:0] mem_waddr;
  logic [HEAD_W-1:0]       mem_wdata;

  // Hash selection: low key bits, or an XOR fold of zero-padded key chunks.
  generate
    if (HASH_TYPE == "xor") begin : g_xor
      logic [KEY_PAD_W-1:0]    key_pad;
      logic [BUCKET_WIDTH-1:0] fold [NUM_CHUNKS];
      assign key_pad = KEY_PAD_W'(cmd_key_i);
      for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_fold
        if (gi == 0) begin : g_first
          assign fold[gi] = key_pad[BUCKET_WIDTH-1:0];
        end else begin : g_next
          assign fold[gi] = fold[gi-1] ^ key_pad[gi*BUCKET_WIDTH +: BUCKET_WIDTH];
        end
      end
      assign cmd_bucket = fold[NUM_CHUNKS-1];
    end else begin : g_dummy
      assign cmd_bucket = cmd_key_i[BUCKET_WIDTH-1:0];
    end
  endgenerate

  assign run         = (state_reg == ST_RUN);
  assign init_done_o = run;

  assign s1_adv      = s1_valid_reg && (!out_valid_reg || pdata_ready_i);
  assign out_load    = s1_adv;
  assign cmd_ready_o = run && (!s1_valid_reg || s1_adv);
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Head writes are only honoured once the sweep has finished.
  assign wr_en      = run && head_wr_en_i;
  assign wr_data    = {head_wr_ptr_val_i, head_wr_ptr_i};
  assign wr_hit_cmd = wr_en && (head_wr_bucket_i == cmd_bucket);
  assign wr_hit_s1  = wr_en && s1_valid_reg && (head_wr_bucket_i == s1_bucket_reg);
  assign wr_hit_out = wr_en && out_valid_reg && (head_wr_bucket_i == out_bucket_reg);

  assign s1_head     = s1_byp_reg ? s1_byp_data_reg : ram_q;
  assign s1_head_fwd = wr_hit_s1 ? wr_data : s1_head;

  // The sweep owns the write port during INIT, the data-table stage after.
  assign mem_we    = !run || wr_en;
  assign mem_waddr = run ? head_wr_bucket_i : init_cnt_reg;
  assign mem_wdata = run ? wr_data : '0;

  // Init sweep counter and INIT -> RUN transition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else if (!run) begin
      init_cnt_reg <= init_cnt_reg + ONE_BUCKET;
      if (init_cnt_reg == LAST_BUCKET) begin
        state_reg <= ST_RUN;
      end
    end
  end

  // Head RAM write port.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      head_mem[mem_waddr] <= mem_wdata;
    end
  end

  // Head RAM registered read, issued on command acceptance.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ram_q <= head_mem[cmd_bucket];
    end
  end

  // s1 and output registers, with head forwarding from the write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_reg    <= 1'b0;
      s1_key_reg      <= '0;
      s1_value_reg    <= '0;
      s1_opcode_reg   <= '0;
      s1_bucket_reg   <= '0;
      s1_byp_reg      <= 1'b0;
      s1_byp_data_reg <= '0;
      out_valid_reg   <= 1'b0;
      out_key_reg     <= '0;
      out_value_reg   <= '0;
      out_opcode_reg  <= '0;
      out_bucket_reg  <= '0;
      out_head_reg    <= '0;
    end else begin
      if (accept) begin
        s1_valid_reg    <= 1'b1;
        s1_key_reg      <= cmd_key_i;
        s1_value_reg    <= cmd_value_i;
        s1_opcode_reg   <= cmd_opcode_i;
        s1_bucket_reg   <= cmd_bucket;
        s1_byp_reg      <= wr_hit_cmd;
        s1_byp_data_reg <= wr_data;
      end else begin
        if (s1_adv) begin
          s1_valid_reg <= 1'b0;
        end
        if (wr_hit_s1) begin
          s1_byp_reg      <= 1'b1;
          s1_byp_data_reg <= wr_data;
        end
      end

      if (out_load) begin
        out_valid_reg  <= 1'b1;
        out_key_reg    <= s1_key_reg;
        out_value_reg  <= s1_value_reg;
        out_opcode_reg <= s1_opcode_reg;
        out_bucket_reg <= s1_bucket_reg;
        out_head_reg   <= s1_head_fwd;
      end else if (pdata_ready_i) begin
        out_valid_reg <= 1'b0;
      end else if (wr_hit_out) begin
        // Held beat: keep its head fields current.
        out_head_reg <= wr_data;
      end
    end
  end

  assign pdata_valid_o        = out_valid_reg;
  assign pdata_key_o          = out_key_reg;
  assign pdata_value_o        = out_value_reg;
  assign pdata_opcode_o       = out_opcode_reg;
  assign pdata_bucket_o       = out_bucket_reg;
  assign pdata_head_ptr_o     = out_head_reg[HEAD_PTR_WIDTH-1:0];
  assign pdata_head_ptr_val_o = out_head_reg[HEAD_PTR_WIDTH];

endmodule

// File: tb/tb_ht_head_table_stage.sv
// Directed testbench for ht_head_table_stage. A second instance using the XOR
// hash shares all inputs with the default instance.
module tb_ht_head_table_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] cmd_key = '0;
  logic [15:0] cmd_value = '0;
  logic [1:0]  cmd_opcode = '0;
  logic        cmd_valid = 1'b0;
  logic        pdata_ready = 1'b0;
  logic        head_wr_en = 1'b0;
  logic [7:0]  head_wr_bucket = '0;
  logic [9:0]  head_wr_ptr = '0;
  logic        head_wr_ptr_val = 1'b0;

  logic        cmd_ready, pdata_valid, pdata_head_ptr_val, init_done;
  logic [47:0] pdata_key;
  logic [15:0] pdata_value;
  logic [1:0]  pdata_opcode;
  logic [7:0]  pdata_bucket;
  logic [9:0]  pdata_head_ptr;

  logic        x_cmd_ready, x_pdata_valid, x_pdata_head_ptr_val, x_init_done;
  logic [47:0] x_pdata_key;
  logic [15:0] x_pdata_value;
  logic [1:0]  x_pdata_opcode;
  logic [7:0]  x_pdata_bucket;
  logic [9:0]  x_pdata_head_ptr;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ht_head_table_stage dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_key_i(cmd_key), .cmd_value_i(cmd_value), .cmd_opcode_i(cmd_opcode),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .pdata_key_o(pdata_key), .pdata_value_o(pdata_value), .pdata_opcode_o(pdata_opcode),
    .pdata_bucket_o(pdata_bucket), .pdata_head_ptr_o(pdata_head_ptr),
    .pdata_head_ptr_val_o(pdata_head_ptr_val), .pdata_valid_o(pdata_valid),
    .pdata_ready_i(pdata_ready),
    .head_wr_en_i(head_wr_en), .head_wr_bucket_i(head_wr_bucket),
    .head_wr_ptr_i(head_wr_ptr), .head_wr_ptr_val_i(head_wr_ptr_val),
    .init_done_o(init_done)
  );

  ht_head_table_stage #(.HASH_TYPE("xor")) dut_x (
    .clk_i(clk), .rst_i(rst),
    .cmd_key_i(cmd_key), .cmd_value_i(cmd_value), .cmd_opcode_i(cmd_opcode),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(x_cmd_ready),
    .pdata_key_o(x_pdata_key), .pdata_value_o(x_pdata_value), .pdata_opcode_o(x_pdata_opcode),
    .pdata_bucket_o(x_pdata_bucket), .pdata_head_ptr_o(x_pdata_head_ptr),
    .pdata_head_ptr_val_o(x_pdata_head_ptr_val), .pdata_valid_o(x_pdata_valid),
    .pdata_ready_i(pdata_ready),
    .head_wr_en_i(head_wr_en), .head_wr_bucket_i(head_wr_bucket),
    .head_wr_ptr_i(head_wr_ptr), .head_wr_ptr_val_i(head_wr_ptr_val),
    .init_done_o(x_init_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [47:0] k, input logic [15:0] v, input logic [1:0] op);
    cmd_key    = k;
    cmd_value  = v;
    cmd_opcode = op;
    cmd_valid  = 1'b1;
  endtask

  task automatic drive_wr(input logic [7:0] b, input logic [9:0] p, input logic pv);
    head_wr_en      = 1'b1;
    head_wr_bucket  = b;
    head_wr_ptr     = p;
    head_wr_ptr_val = pv;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick; tick;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b, expected 0", cmd_ready); else pass_cnt++;
    total_cnt++; if (pdata_valid !== 1'b0) $display("FAIL reset_pdata_valid: got %b, expected 0", pdata_valid); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b, expected 0", init_done); else pass_cnt++;
    total_cnt++; if (pdata_key !== 48'h0) $display("FAIL reset_pdata_key: got %h, expected 0", pdata_key); else pass_cnt++;
    total_cnt++; if ({pdata_head_ptr_val, pdata_head_ptr} !== 11'h0) $display("FAIL reset_head: got %h, expected 0", {pdata_head_ptr_val, pdata_head_ptr}); else pass_cnt++;
    $display("txn reset: cmd_ready=%b pdata_valid=%b init_done=%b", cmd_ready, pdata_valid, init_done);
  endtask

  task automatic test_init_sweep;
    int n;
    n = 0;
    rst = 1'b0;
    #1;
    while (!init_done && n < 400) begin
      tick;
      n++;
    end
    total_cnt++; if (n !== 256) $display("FAIL init_cycles: got %0d, expected 256", n); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL init_cmd_ready: got %b, expected 1", cmd_ready); else pass_cnt++;
    $display("txn init: done after %0d cycles", n);
    // first SEARCH after the sweep
    pdata_ready = 1'b1;
    drive_cmd(48'h000000000005, 16'hAAAA, 2'd0);
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL search0_accept: got %b, expected 1", cmd_ready); else pass_cnt++;
    tick;
    cmd_valid = 1'b0;
    total_cnt++; if (pdata_valid !== 1'b0) $display("FAIL search0_early: got %b, expected 0", pdata_valid); else pass_cnt++;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1) $display("FAIL search0_valid: got %b, expected 1", pdata_valid); else pass_cnt++;
    total_cnt++; if (pdata_bucket !== 8'h05) $display("FAIL search0_bucket: got %h, expected 05", pdata_bucket); else pass_cnt++;
    total_cnt++; if (pdata_head_ptr_val !== 1'b0) $display("FAIL search0_hval: got %b, expected 0", pdata_head_ptr_val); else pass_cnt++;
    total_cnt++; if (pdata_key !== 48'h000000000005) $display("FAIL search0_key: got %h, expected 000000000005", pdata_key); else pass_cnt++;
    total_cnt++; if (pdata_value !== 16'hAAAA) $display("FAIL search0_value: got %h, expected aaaa", pdata_value); else pass_cnt++;
    total_cnt++; if (pdata_opcode !== 2'd0) $display("FAIL search0_opcode: got %0d, expected 0", pdata_opcode); else pass_cnt++;
    $display("txn search key=5: bucket=%h ptr=%h val=%b", pdata_bucket, pdata_head_ptr, pdata_head_ptr_val);
    tick;
  endtask

  task automatic test_head_write;
    drive_wr(8'h05, 10'h123, 1'b1);
    tick;
    head_wr_en = 1'b0;
    drive_cmd(48'h000000000005, 16'h0001, 2'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    total_cnt++; if (pdata_head_ptr !== 10'h123) $display("FAIL hw_ptr: got %h, expected 123", pdata_head_ptr); else pass_cnt++;
    total_cnt++; if (pdata_head_ptr_val !== 1'b1) $display("FAIL hw_val: got %b, expected 1", pdata_head_ptr_val); else pass_cnt++;
    $display("txn head write/read bucket 05: ptr=%h val=%b", pdata_head_ptr, pdata_head_ptr_val);
    tick;
  endtask

  task automatic test_hazard;
    // write lands in the acceptance cycle: RAM read-during-write
    drive_cmd(48'h000000000007, 16'h0707, 2'd1);
    drive_wr(8'h07, 10'h055, 1'b1);
    tick;
    cmd_valid  = 1'b0;
    head_wr_en = 1'b0;
    tick;
    total_cnt++; if (pdata_head_ptr !== 10'h055) $display("FAIL rdw_ptr: got %h, expected 055", pdata_head_ptr); else pass_cnt++;
    total_cnt++; if (pdata_head_ptr_val !== 1'b1) $display("FAIL rdw_val: got %b, expected 1", pdata_head_ptr_val); else pass_cnt++;
    total_cnt++; if (pdata_opcode !== 2'd1) $display("FAIL rdw_opcode: got %0d, expected 1", pdata_opcode); else pass_cnt++;
    $display("txn same-cycle hazard: ptr=%h val=%b", pdata_head_ptr, pdata_head_ptr_val);
    tick;
    // set bucket 07 to a different value so a missed s1 bypass is visible
    drive_wr(8'h07, 10'h0AA, 1'b0);
    tick;
    head_wr_en = 1'b0;
    drive_cmd(48'h000000000007, 16'h0708, 2'd1);
    tick;
    cmd_valid = 1'b0;
    drive_wr(8'h07, 10'h055, 1'b1);
    tick;
    head_wr_en = 1'b0;
    total_cnt++; if (pdata_head_ptr !== 10'h055) $display("FAIL s1byp_ptr: got %h, expected 055", pdata_head_ptr); else pass_cnt++;
    total_cnt++; if (pdata_head_ptr_val !== 1'b1) $display("FAIL s1byp_val: got %b, expected 1", pdata_head_ptr_val); else pass_cnt++;
    $display("txn s1 bypass hazard: ptr=%h val=%b", pdata_head_ptr, pdata_head_ptr_val);
    tick;
  endtask

  task automatic test_back_to_back;
    pdata_ready = 1'b1;
    drive_cmd(48'h000000000011, 16'h1111, 2'd0);
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready1: got %b, expected 1", cmd_ready); else pass_cnt++;
    tick;
    drive_cmd(48'h000000000012, 16'h2222, 2'd1);
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready2: got %b, expected 1", cmd_ready); else pass_cnt++;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1 || pdata_key !== 48'h11) $display("FAIL b2b_beat1: got valid=%b key=%h, expected valid=1 key=11", pdata_valid, pdata_key); else pass_cnt++;
    $display("txn b2b beat key=%h bucket=%h", pdata_key, pdata_bucket);
    drive_cmd(48'h000000000013, 16'h3333, 2'd2);
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready3: got %b, expected 1", cmd_ready); else pass_cnt++;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1 || pdata_key !== 48'h12 || pdata_opcode !== 2'd1) $display("FAIL b2b_beat2: got valid=%b key=%h op=%0d, expected 1/12/1", pdata_valid, pdata_key, pdata_opcode); else pass_cnt++;
    $display("txn b2b beat key=%h bucket=%h", pdata_key, pdata_bucket);
    cmd_valid = 1'b0;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1 || pdata_key !== 48'h13 || pdata_value !== 16'h3333) $display("FAIL b2b_beat3: got valid=%b key=%h value=%h, expected 1/13/3333", pdata_valid, pdata_key, pdata_value); else pass_cnt++;
    total_cnt++; if (pdata_bucket !== 8'h13) $display("FAIL b2b_bucket3: got %h, expected 13", pdata_bucket); else pass_cnt++;
    $display("txn b2b beat key=%h bucket=%h", pdata_key, pdata_bucket);
    tick;
    total_cnt++; if (pdata_valid !== 1'b0) $display("FAIL b2b_drain: got %b, expected 0", pdata_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    pdata_ready = 1'b0;
    drive_cmd(48'h000000000005, 16'h000A, 2'd0);
    tick;
    drive_cmd(48'h00000000000B, 16'h000B, 2'd1);
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready_b: got %b, expected 1", cmd_ready); else pass_cnt++;
    tick;
    drive_cmd(48'h00000000000C, 16'h000C, 2'd2);
    #1;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready_full: got %b, expected 0", cmd_ready); else pass_cnt++;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1 || pdata_key !== 48'h05 || pdata_head_ptr !== 10'h123) $display("FAIL bp_hold: got valid=%b key=%h ptr=%h, expected 1/05/123", pdata_valid, pdata_key, pdata_head_ptr); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready_still: got %b, expected 0", cmd_ready); else pass_cnt++;
    drive_wr(8'h05, 10'h3FF, 1'b1);
    tick;
    head_wr_en = 1'b0;
    total_cnt++; if (pdata_head_ptr !== 10'h3FF || pdata_key !== 48'h05) $display("FAIL bp_out_bypass: got ptr=%h key=%h, expected 3ff/05", pdata_head_ptr, pdata_key); else pass_cnt++;
    $display("txn backpressure held beat key=%h ptr=%h", pdata_key, pdata_head_ptr);
    pdata_ready = 1'b1;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, expected 1", cmd_ready); else pass_cnt++;
    tick;
    cmd_valid = 1'b0;
    total_cnt++; if (pdata_key !== 48'h0B || pdata_head_ptr_val !== 1'b0 || pdata_bucket !== 8'h0B) $display("FAIL bp_beat_b: got key=%h val=%b bucket=%h, expected 0b/0/0b", pdata_key, pdata_head_ptr_val, pdata_bucket); else pass_cnt++;
    $display("txn backpressure beat key=%h", pdata_key);
    tick;
    total_cnt++; if (pdata_valid !== 1'b1 || pdata_key !== 48'h0C || pdata_opcode !== 2'd2) $display("FAIL bp_beat_c: got valid=%b key=%h op=%0d, expected 1/0c/2", pdata_valid, pdata_key, pdata_opcode); else pass_cnt++;
    $display("txn backpressure beat key=%h", pdata_key);
    tick;
    total_cnt++; if (pdata_valid !== 1'b0) $display("FAIL bp_drain: got %b, expected 0", pdata_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    pdata_ready = 1'b0;
    drive_cmd(48'h000000000005, 16'h0055, 2'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b, expected 1", pdata_valid); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (pdata_valid !== 1'b0) $display("FAIL rmid_async_valid: got %b, expected 0", pdata_valid); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL rmid_state: got init_done=%b ready=%b, expected 0/0", init_done, cmd_ready); else pass_cnt++;
    $display("txn reset mid-operation: pdata_valid=%b", pdata_valid);
    tick; tick;
    rst = 1'b0;
    n = 0;
    #1;
    while (!init_done && n < 400) begin
      tick;
      n++;
    end
    total_cnt++; if (n !== 256) $display("FAIL rmid_init_cycles: got %0d, expected 256", n); else pass_cnt++;
    pdata_ready = 1'b1;
    drive_cmd(48'h000000000005, 16'h0056, 2'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    total_cnt++; if (pdata_valid !== 1'b1 || pdata_bucket !== 8'h05) $display("FAIL rmid_search: got valid=%b bucket=%h, expected 1/05", pdata_valid, pdata_bucket); else pass_cnt++;
    total_cnt++; if (pdata_head_ptr_val !== 1'b0 || pdata_head_ptr !== 10'h0) $display("FAIL rmid_cleared: got val=%b ptr=%h, expected 0/000", pdata_head_ptr_val, pdata_head_ptr); else pass_cnt++;
    $display("txn resweep search key=5: ptr=%h val=%b", pdata_head_ptr, pdata_head_ptr_val);
    tick;
  endtask

  task automatic test_xor_hash;
    pdata_ready = 1'b1;
    drive_cmd(48'h010203040506, 16'h0BAD, 2'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    total_cnt++; if (x_pdata_valid !== 1'b1 || x_pdata_bucket !== 8'h07) $display("FAIL xor_bucket: got valid=%b bucket=%h, expected 1/07", x_pdata_valid, x_pdata_bucket); else pass_cnt++;
    total_cnt++; if (pdata_bucket !== 8'h06) $display("FAIL dummy_bucket: got %h, expected 06", pdata_bucket); else pass_cnt++;
    total_cnt++; if (x_pdata_key !== 48'h010203040506) $display("FAIL xor_key: got %h, expected 010203040506", x_pdata_key); else pass_cnt++;
    $display("txn xor hash key=010203040506: xor bucket=%h dummy bucket=%h", x_pdata_bucket, pdata_bucket);
    tick;
  endtask

  initial begin
    test_reset;
    test_init_sweep;
    test_head_write;
    test_hazard;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_xor_hash;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
